huff_stream_encoder: RTL

- Streaming, parametrised successor to the one-shot Huffman encoder.
- A code table (one code/length pair per symbol) is loaded by the tree builder. Symbols then flow in one per handshake.
- Variable-length codes are concatenated MSB-first and packed into fixed OUT_W-bit output words.
- Packets are delimited by last flags. The final word is zero-padded and carries a valid-bit count.

---
 rtl/huff_pkg.sv | 14 +
 rtl/huff_code_table.sv | 37 +++
 rtl/huff_stream_encoder.sv | 122 ++++++++++++
 3 files changed

// File: rtl/huff_pkg.sv
// huff_pkg: shared types and default parameters for the streaming Huffman encoder.
package huff_pkg;
    localparam int SYM_W_DEF   = 4;
    localparam int MAX_LEN_DEF = 8;
    localparam int OUT_W_DEF   = 16;
    localparam int LEN_W_DEF   = $clog2(MAX_LEN_DEF + 1);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH} huff_enc_state_t;

    typedef struct packed {
        logic [MAX_LEN_DEF-1:0] code;
        logic [LEN_W_DEF-1:0]   len;
    } huff_code_t;
endpackage

// File: rtl/huff_code_table.sv
// huff_code_table: per-symbol code/length register file, async read, writes blocked while busy.
module huff_code_table #(
    parameter int SYM_W   = 4,
    parameter int MAX_LEN = 8,
    parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               busy_i,
    input  logic               we_i,
    input  logic [SYM_W-1:0]   waddr_i,
    input  logic [MAX_LEN-1:0] wcode_i,
    input  logic [LEN_W-1:0]   wlen_i,
    input  logic [SYM_W-1:0]   raddr_i,
    output logic [MAX_LEN-1:0] rcode_o,
    output logic [LEN_W-1:0]   rlen_o
);
    localparam int NUM_SYM = 1 << SYM_W;

    logic [MAX_LEN-1:0] code_q [NUM_SYM];
    logic [LEN_W-1:0]   len_q  [NUM_SYM];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_SYM; i++) begin
                code_q[i] <= '0;
                len_q[i]  <= '0;
            end
        end else if (we_i && !busy_i) begin
            code_q[waddr_i] <= wcode_i;
            len_q[waddr_i]  <= wlen_i > LEN_W'(MAX_LEN) ? LEN_W'(MAX_LEN) : wlen_i;
        end
    end

    assign rcode_o = code_q[raddr_i];
    assign rlen_o  = len_q[raddr_i];
endmodule

// File: rtl/huff_stream_encoder.sv
// huff_stream_encoder: packs table-driven variable-length codes MSB-first into OUT_W-bit words,
// one packet per in_last, final word zero-padded with a valid-bit count.
module huff_stream_encoder
    import huff_pkg::*;
#(
    parameter int SYM_W   = SYM_W_DEF,
    parameter int MAX_LEN = MAX_LEN_DEF,
    parameter int OUT_W   = OUT_W_DEF,
    parameter int LEN_W   = $clog2(MAX_LEN + 1),
    parameter int CNT_W   = $clog2(OUT_W + MAX_LEN + 1)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       tbl_we,
    input  logic [SYM_W-1:0]           tbl_addr,
    input  logic [MAX_LEN-1:0]         tbl_code,
    input  logic [LEN_W-1:0]           tbl_len,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [SYM_W-1:0]           in_sym,
    input  logic                       in_last,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [OUT_W-1:0]           out_data,
    output logic [$clog2(OUT_W+1)-1:0] out_bits,
    output logic                       out_last,
    output logic                       busy,
    output logic                       err_len0
);
    localparam int ACC_W = OUT_W + MAX_LEN;
    localparam int OB_W  = $clog2(OUT_W + 1);

    huff_enc_state_t   state_q, state_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              out_valid_q, out_valid_d;
    logic [OUT_W-1:0]  out_data_q, out_data_d;
    logic [OB_W-1:0]   out_bits_q, out_bits_d;
    logic              out_last_q, out_last_d;
    logic              err_q, err_d;
    logic [MAX_LEN-1:0] t_code, code_m;
    logic [LEN_W-1:0]  t_len;
    logic [CNT_W-1:0]  shamt;
    logic              full, accept, emit;

    huff_code_table #(.SYM_W(SYM_W), .MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) u_table (
        .clk     (clk),
        .reset   (reset),
        .busy_i  (busy),
        .we_i    (tbl_we),
        .waddr_i (tbl_addr),
        .wcode_i (tbl_code),
        .wlen_i  (tbl_len),
        .raddr_i (in_sym),
        .rcode_o (t_code),
        .rlen_o  (t_len)
    );

    assign full     = cnt_q >= CNT_W'(OUT_W);
    assign in_ready = state_q != FLUSH && !full;
    assign accept   = in_valid && in_ready;
    // once the out_last word is loaded, FLUSH only waits for its handshake
    assign emit     = (!out_valid_q || out_ready)
                   && (full || (state_q == FLUSH && !(out_valid_q && out_last_q)));
    assign busy     = state_q != IDLE || cnt_q != '0 || out_valid_q;
    assign code_m   = t_code & ((MAX_LEN'(1) << t_len) - MAX_LEN'(1));
    assign shamt    = CNT_W'(ACC_W) - cnt_q - CNT_W'(t_len);

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q && !out_ready;
        out_data_d  = out_data_q;
        out_bits_d  = out_bits_q;
        out_last_d  = out_last_q;
        err_d       = err_q || (accept && t_len == '0);
        if (emit) begin
            acc_d       = acc_q << OUT_W;
            cnt_d       = full ? cnt_q - CNT_W'(OUT_W) : '0;
            out_valid_d = 1'b1;
            out_data_d  = acc_q[ACC_W-1 -: OUT_W];
            out_bits_d  = full ? OB_W'(OUT_W) : OB_W'(cnt_q);
            out_last_d  = state_q == FLUSH && cnt_q <= CNT_W'(OUT_W);
        end else if (accept) begin
            acc_d = acc_q | (ACC_W'(code_m) << shamt);
            cnt_d = cnt_q + CNT_W'(t_len);
        end
        if (accept)
            state_d = in_last ? FLUSH : RUN;
        else if (state_q == FLUSH && out_valid_q && out_ready && out_last_q)
            state_d = IDLE;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_bits_q  <= '0;
            out_last_q  <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_bits_q  <= out_bits_d;
            out_last_q  <= out_last_d;
            err_q       <= err_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_bits  = out_bits_q;
    assign out_last  = out_last_q;
    assign err_len0  = err_q;
endmodule
